// File: rtl/adc_frame_capture.sv
// Oversampled SPI MISO frame deserializer: one status word plus NUM_CHANNELS channel words per CS-low frame.
// Optional macro ADC_CAPTURE_DROP_CNT_EN adds a saturating drop_count of frames lost to a full output buffer.
module adc_frame_capture #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WORD_BITS    = 16,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                                  system_clock,
  input  logic                                  reset,
  input  logic                                  spi_sclk,
  input  logic                                  spi_cs_n,
  input  logic                                  spi_miso,
  input  logic                                  capture_en,
  output logic [(NUM_CHANNELS+1)*DATA_BITS-1:0] frame_data,
  output logic                                  frame_valid,
  input  logic                                  frame_ready,
  output logic                                  busy,
  output logic                                  frame_error,
  output logic [3:0]                            word_index
`ifdef ADC_CAPTURE_DROP_CNT_EN
  ,
  output logic [7:0]                            drop_count
`endif
);

  localparam int unsigned NUM_WORDS  = NUM_CHANNELS + 1;
  localparam int unsigned FRAME_BITS = NUM_WORDS * DATA_BITS;
  localparam int unsigned BIT_CNT_W  = $clog2(WORD_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_BITS - 1);
  localparam logic [3:0]           LAST_WORD = 4'(NUM_CHANNELS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, miso_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, miso_s;
  logic                   sclk_fall, cs_fall, cs_rise;

  // Shift register holds WORD_BITS-1 bits; the incoming bit completes the word.
  logic [WORD_BITS-2:0]   shift_q, shift_d;
  logic [WORD_BITS-1:0]   shift_next;
  logic [DATA_BITS-1:0]   word_top;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]             word_index_d;
  logic [DATA_BITS-1:0]   stage_q [NUM_WORDS];
  logic [FRAME_BITS-1:0]  stage_flat;
  logic                   stage_we, load, error_d, valid_d, busy_d, frame_done;
`ifdef ADC_CAPTURE_DROP_CNT_EN
  logic                   drop;
`endif

  // Input synchronisers plus one extra stage on sclk/cs for edge detection
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      miso_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      miso_sync <= {miso_sync[SYNC_STAGES-2:0], spi_miso};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign miso_s     = miso_sync[SYNC_STAGES-1];
  assign sclk_fall  = sclk_prev & ~sclk_s;
  assign cs_fall    = cs_prev & ~cs_s;
  assign cs_rise    = ~cs_prev & cs_s;
  assign shift_next = {shift_q, miso_s};
  assign word_top   = shift_next[WORD_BITS-1 -: DATA_BITS];
  assign frame_done = sclk_fall && (bit_cnt_q == LAST_BIT) && (word_index == LAST_WORD);

  always_comb begin
    stage_flat = '0;
    for (int k = 0; k < NUM_WORDS; k++) stage_flat[k*DATA_BITS +: DATA_BITS] = stage_q[k];
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state_q <= WAIT_CS;
    else       state_q <= state_d;
  end

  // Next state, datapath controls and registered-output next values
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_index_d = word_index;
    stage_we     = 1'b0;
    load         = 1'b0;
    error_d      = 1'b0;
`ifdef ADC_CAPTURE_DROP_CNT_EN
    drop         = 1'b0;
`endif
    case (state_q)
      WAIT_CS: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          if (capture_en) begin
            state_d      = SHIFT;
            shift_d      = '0;
            bit_cnt_d    = '0;
            word_index_d = '0;
          end else begin
            state_d = WAIT_CS;
          end
        end
      end
      SHIFT: begin
        if (cs_rise && !frame_done) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          shift_d = shift_next[WORD_BITS-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            stage_we  = 1'b1;
            if (word_index == LAST_WORD) state_d = DONE;
            else                         word_index_d = word_index + 4'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = WAIT_CS;
        if (!frame_valid || frame_ready) load = 1'b1;
`ifdef ADC_CAPTURE_DROP_CNT_EN
        else drop = 1'b1;
`endif
      end
      default: state_d = WAIT_CS;
    endcase

    valid_d = frame_valid;
    if (load)                            valid_d = 1'b1;
    else if (frame_valid && frame_ready) valid_d = 1'b0;
    busy_d = (state_d == SHIFT) || (state_d == DONE);
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_index  <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) stage_q[k] <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_index  <= word_index_d;
      frame_valid <= valid_d;
      busy        <= busy_d;
      frame_error <= error_d;
      if (stage_we) begin
        for (int k = 0; k < NUM_WORDS; k++)
          if (word_index == 4'(k)) stage_q[k] <= word_top;
      end
      if (load) frame_data <= stage_flat;
    end
  end

`ifdef ADC_CAPTURE_DROP_CNT_EN
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset)                            drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture: timeline model of the output buffer plus directed literal checks.
module tb_adc_frame_capture;
  localparam int unsigned NCH  = 4;
  localparam int unsigned WB   = 16;
  localparam int unsigned DB   = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 4;
  localparam int unsigned FW   = (NCH + 1) * DB;

  logic          system_clock = 1'b0;
  logic          reset = 1'b1;
  logic          spi_sclk = 1'b0, spi_miso = 1'b0, spi_cs_n = 1'b1, spi_cs_n_b = 1'b1;
  logic          capture_en = 1'b1, frame_ready = 1'b1, frame_ready_b = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid, busy, frame_error;
  logic [3:0]    word_index;
  logic [71:0]   frame_data_b;
  logic          frame_valid_b, busy_b, frame_error_b;
  logic [3:0]    word_index_b;
`ifdef ADC_CAPTURE_DROP_CNT_EN
  logic [7:0]    drop_count, drop_count_b;
`endif

  always #10 system_clock = ~system_clock;

  adc_frame_capture #(.NUM_CHANNELS(NCH), .WORD_BITS(WB), .DATA_BITS(DB), .SYNC_STAGES(SYNC)) u_dut (
    .system_clock(system_clock), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .capture_en(capture_en), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .frame_error(frame_error), .word_index(word_index)
`ifdef ADC_CAPTURE_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  adc_frame_capture #(.NUM_CHANNELS(2), .WORD_BITS(24), .DATA_BITS(24), .SYNC_STAGES(SYNC)) u_dut_b (
    .system_clock(system_clock), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n_b),
    .spi_miso(spi_miso), .capture_en(capture_en), .frame_data(frame_data_b), .frame_valid(frame_valid_b),
    .frame_ready(frame_ready_b), .busy(busy_b), .frame_error(frame_error_b), .word_index(word_index_b)
`ifdef ADC_CAPTURE_DROP_CNT_EN
    , .drop_count(drop_count_b)
`endif
  );

  // Model: the driver stamps the posedge number at which each effect must become visible.
  int            cyc = 0, on_at = -1, off_at = -1, err_at = -1, load_at = -1;
  logic [FW-1:0] load_data = '0, exp_data = '0;
  logic          exp_valid = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  int            drops = 0;

  always @(posedge system_clock) begin
    cyc = cyc + 1;
    exp_err = 1'b0;
    if (reset) begin
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      drops     = 0;
    end else begin
      if (cyc == on_at)  exp_busy = 1'b1;
      if (cyc == off_at) exp_busy = 1'b0;
      if (cyc == err_at) exp_err  = 1'b1;
      if (cyc == load_at) begin
        if (!exp_valid || frame_ready) begin
          exp_valid = 1'b1;
          exp_data  = load_data;
        end else if (drops < 255) begin
          drops = drops + 1;
        end
      end else if (exp_valid && frame_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  int            total = 0, bad = 0;
  int            valid_rises = 0, err_pulses = 0, busy_rises = 0, xfers = 0;
  logic          prev_valid = 1'b0, prev_busy = 1'b0;
  logic [FW-1:0] seen_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Split an MSB-first bit stream into words and keep the top DB bits of each, word 0 in the low slot.
  function automatic logic [FW-1:0] frame_of(input logic [127:0] s, input int nbits);
    logic [FW-1:0] f;
    logic [WB-1:0] w;
    f = '0;
    for (int j = 0; j <= int'(NCH); j++) begin
      w = s[nbits-1-j*int'(WB) -: WB];
      f[j*int'(DB) +: DB] = w[WB-1 -: DB];
    end
    return f;
  endfunction

  task automatic send(input logic [127:0] stream, input int nbits, input int nsclk, input bit cap_in,
                      input bit sel_b, input int rst_at, input bit rdy_done);
    bit cap;
    cap = cap_in && !sel_b;
    @(negedge system_clock);
    if (sel_b) spi_cs_n_b = 1'b0;
    else       spi_cs_n   = 1'b0;
    if (cap) on_at = cyc + int'(SYNC) + 1;
    repeat (4) @(negedge system_clock);
    for (int i = 0; i < nsclk; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (3) @(negedge system_clock);
        reset = 1'b0;
        cap = 1'b0;
      end
      spi_sclk = 1'b1;
      spi_miso = (i < nbits) ? stream[nbits-1-i] : 1'b0;
      repeat (HALF) @(negedge system_clock);
      spi_sclk = 1'b0;
      if (cap && i == nbits - 1) begin
        load_at   = cyc + int'(SYNC) + 2;
        off_at    = cyc + int'(SYNC) + 2;
        load_data = frame_of(stream, nbits);
      end
      for (int c = 1; c <= int'(HALF); c++) begin
        @(negedge system_clock);
        if (rdy_done && i == nbits - 1) begin
          if (c == int'(SYNC) + 1) frame_ready = 1'b1;
          if (c == int'(SYNC) + 2) frame_ready = 1'b0;
        end
      end
    end
    repeat (4) @(negedge system_clock);
    if (sel_b) spi_cs_n_b = 1'b1;
    else       spi_cs_n   = 1'b1;
    if (cap && nsclk < nbits) begin
      err_at = cyc + int'(SYNC) + 1;
      off_at = cyc + int'(SYNC) + 1;
    end
    repeat (8) @(negedge system_clock);
  endtask

  initial begin
    int r0, e0, b0, x0;
    fork
      forever begin
        @(negedge system_clock);
        if (!reset) begin
          chk("frame_valid", 128'(frame_valid), 128'(exp_valid));
          chk("frame_error", 128'(frame_error), 128'(exp_err));
          chk("busy", 128'(busy), 128'(exp_busy));
          if (exp_valid) chk("frame_data", 128'(frame_data), 128'(exp_data));
`ifdef ADC_CAPTURE_DROP_CNT_EN
          chk("drop_count", 128'(drop_count), 128'(8'(drops)));
`endif
          if (frame_valid) seen_data = frame_data;
          if (frame_valid && !prev_valid) valid_rises = valid_rises + 1;
          if (busy && !prev_busy) busy_rises = busy_rises + 1;
          if (frame_error) err_pulses = err_pulses + 1;
          if (frame_valid && frame_ready) xfers = xfers + 1;
          prev_valid = frame_valid;
          prev_busy  = busy;
        end
      end
    join_none

    repeat (3) @(negedge system_clock);
    chk("rst_valid", 128'(frame_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_error", 128'(frame_error), 128'(0));
    chk("rst_word_index", 128'(word_index), 128'(0));
    chk("rst_data", 128'(frame_data), 128'(0));
    chk("rst_valid_b", 128'(frame_valid_b), 128'(0));
    reset = 1'b0;
    repeat (10) @(negedge system_clock);

    // Full default frame, consumer always ready
    r0 = valid_rises;
    send(128'({16'h2200, 16'h1234, 16'hABCD, 16'h8000, 16'h7FFF}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    chk("model_f1", 128'(exp_data), 128'(80'h7FFF_8000_ABCD_1234_2200));
    chk("t1_data", 128'(seen_data), 128'(80'h7FFF_8000_ABCD_1234_2200));
    chk("t1_pulses", 128'(valid_rises - r0), 128'(1));
    chk("t1_word_index", 128'(word_index), 128'(4));

    // 24-bit words, two channels
    send(128'({24'h220000, 24'h800001, 24'h7FFFFE}), 72, 72, 1'b1, 1'b1, -1, 1'b0);
    chk("b_valid", 128'(frame_valid_b), 128'(1));
    chk("b_data", 128'(frame_data_b), 128'(72'h7FFFFE_800001_220000));
    chk("b_error", 128'(frame_error_b), 128'(0));
    chk("b_busy", 128'(busy_b), 128'(0));
    chk("b_word_index", 128'(word_index_b), 128'(2));
`ifdef ADC_CAPTURE_DROP_CNT_EN
    chk("b_drops", 128'(drop_count_b), 128'(0));
`endif

    // Truncated after 37 SCLKs, then a full frame with extra trailing SCLKs
    e0 = err_pulses;
    r0 = valid_rises;
    send(128'({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234}), 80, 37, 1'b1, 1'b0, -1, 1'b0);
    chk("t3_err_pulses", 128'(err_pulses - e0), 128'(1));
    chk("t3_no_valid", 128'(valid_rises - r0), 128'(0));
    chk("t3_word_index", 128'(word_index), 128'(2));
    send(128'({16'h0001, 16'hFFFF, 16'h5A5A, 16'hA5A5, 16'h0F0F}), 80, 84, 1'b1, 1'b0, -1, 1'b0);
    chk("t3_data", 128'(seen_data), 128'(80'h0F0F_A5A5_5A5A_FFFF_0001));

    // Consumer stalled across three frames
    frame_ready = 1'b0;
    b0 = busy_rises;
    send(128'({16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    send(128'({16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    send(128'({16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    chk("t4_valid", 128'(frame_valid), 128'(1));
    chk("t4_data", 128'(frame_data), 128'(80'h5555_4444_3333_2222_1111));
    chk("t4_busy_rises", 128'(busy_rises - b0), 128'(3));
    chk("model_drops", 128'(drops), 128'(2));
`ifdef ADC_CAPTURE_DROP_CNT_EN
    chk("t4_drop_count", 128'(drop_count), 128'(2));
`endif
    x0 = xfers;
    @(posedge system_clock);
    #1 frame_ready = 1'b1;
    @(posedge system_clock);
    #1 frame_ready = 1'b0;
    repeat (4) @(negedge system_clock);
    chk("t4_xfers", 128'(xfers - x0), 128'(1));
    chk("t4_valid_after", 128'(frame_valid), 128'(0));

    // Accept and reload in the same cycle
    send(128'({16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    send(128'({16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005}), 80, 80, 1'b1, 1'b0, -1, 1'b1);
    chk("t5_valid", 128'(frame_valid), 128'(1));
    chk("t5_data", 128'(frame_data), 128'(80'hB005_B004_B003_B002_B001));
`ifdef ADC_CAPTURE_DROP_CNT_EN
    chk("t5_drop_count", 128'(drop_count), 128'(2));
`endif

    // Reset mid-frame with CS held low, then normal capture, then a disarmed frame
    frame_ready = 1'b1;
    e0 = err_pulses;
    r0 = valid_rises;
    send(128'({16'h1357, 16'h2468, 16'h369C, 16'h48AD, 16'h5BCE}), 80, 60, 1'b1, 1'b0, 20, 1'b0);
    chk("t6_no_valid", 128'(valid_rises - r0), 128'(0));
    chk("t6_no_error", 128'(err_pulses - e0), 128'(0));
    chk("t6_valid", 128'(frame_valid), 128'(0));
    send(128'({16'hC000, 16'h0C00, 16'h00C0, 16'h000C, 16'hFFFE}), 80, 80, 1'b1, 1'b0, -1, 1'b0);
    chk("t6_data", 128'(seen_data), 128'(80'hFFFE_000C_00C0_0C00_C000));
    chk("t6_pulses", 128'(valid_rises - r0), 128'(1));
    capture_en = 1'b0;
    b0 = busy_rises;
    r0 = valid_rises;
    send(128'({16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555}), 80, 80, 1'b0, 1'b0, -1, 1'b0);
    chk("t6_disarmed_busy", 128'(busy_rises - b0), 128'(0));
    chk("t6_disarmed_valid", 128'(valid_rises - r0), 128'(0));
    capture_en = 1'b1;

    repeat (4) @(negedge system_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_frame_capture.md
Name: adc_frame_capture

Overview:
- Parametrised SPI MISO frame deserializer for the ADS131A0x ADC; successor to the fixed 16-bit negedge capture register.
- Oversamples SPI_SCLK, SPI_CS and SPI_MISO in the system_clock domain and assembles one status word plus NUM_CHANNELS channel words per CS-low frame.
- Presents each complete frame on a single-entry valid/ready output buffer.
- Sits beside SPI_Master in the ADS131A0X wrapper and feeds downstream sample processing.

Parameters:
- NUM_CHANNELS, 4, channel words per frame after the status word (1..8).
- WORD_BITS, 16, SPI word length in bits (16, 24 or 32).
- DATA_BITS, 16, MSB-aligned bits kept per word (1..WORD_BITS).
- SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_cs_n and spi_miso (>=2).

Ports:
- system_clock  in  1  50 MHz system clock
- reset  in  1  asynchronous active-high reset
- spi_sclk  in  1  SPI clock observed from the bus
- spi_cs_n  in  1  SPI chip select, active low
- spi_miso  in  1  SPI MISO
- capture_en  in  1  arms capture; sampled only at the CS falling edge
- frame_data  out  (NUM_CHANNELS+1)*DATA_BITS  word 0 (status) in bits [DATA_BITS-1:0]; channel k in slice k+1
- frame_valid  out  1  frame_data holds an unconsumed frame
- frame_ready  in  1  consumer accepts the frame
- busy  out  1  high in SHIFT and DONE
- frame_error  out  1  one-cycle pulse on a truncated frame
- word_index  out  4  index of the word currently being shifted (debug)

Behaviour:
- Reset values: all outputs 0, FSM in WAIT_CS, all counters 0.
- Sync and edge detect:
  - All three inputs pass through SYNC_STAGES flops; a further registered copy of spi_sclk and spi_cs_n is kept for edge detection.
  - sclk_fall = synced sclk 1->0. cs_fall and cs_rise are defined the same way on synced spi_cs_n.
  - Requires system_clock >= 4x SCLK (50 MHz vs 4.167 MHz meets this).
- FSM states: IDLE, SHIFT, DONE, WAIT_CS.
  - WAIT_CS: entered from reset and after every frame. Goes to IDLE when synced cs_n is high. A CS held low across reset release is therefore never captured mid-frame.
  - IDLE: on cs_fall with capture_en=1, go to SHIFT and clear bit_cnt, word_index and the shift register. With capture_en=0 the frame is ignored and the FSM goes to WAIT_CS.
  - SHIFT: on each sclk_fall, shift = {shift[WORD_BITS-2:0], miso_sync} (MSB first) and bit_cnt increments.
    - When bit_cnt reaches WORD_BITS-1 on a sclk_fall, the assembled word's top DATA_BITS bits go to slot word_index in the staging buffer, bit_cnt wraps to 0 and word_index increments.
    - Completing word NUM_CHANNELS sends the FSM to DONE.
  - SHIFT, cs_rise before the frame completes: frame_error pulses high for 1 cycle, the staging buffer is discarded, the FSM goes to IDLE and frame_valid is untouched.
  - DONE (exactly 1 cycle): if frame_valid=0 or frame_ready=1 in this cycle, the staging buffer goes to frame_data and frame_valid=1 next cycle. Otherwise the frame is dropped. Then WAIT_CS.
  - Extra SCLK edges after the last word are ignored.
  - capture_en changes mid-frame have no effect.
- Latency: frame_valid rises 2 cycles after the cycle in which the final sclk_fall is detected. Pin-to-detect latency is SYNC_STAGES+1 cycles.
- Handshake:
  - Transfer occurs when frame_valid and frame_ready are both high in the same cycle; frame_valid then clears next cycle unless DONE reloads in that same cycle.
  - A simultaneous accept and reload keeps frame_valid high with the new data; no drop occurs.
  - frame_data is stable while frame_valid=1 and not accepted.
- word_index saturates at NUM_CHANNELS; it is never written past the last slot.
- Asynchronous reset mid-frame aborts immediately with no frame_error and no frame_valid.

Optional Feature:
- Macro ADC_CAPTURE_DROP_CNT_EN.
- Defined: adds output drop_count [7:0], reset 0, incremented (saturating at 255) on each frame dropped in DONE because the buffer was full. Truncated frames are not counted.
- Undefined: the port and counter are absent; dropped frames are silently discarded.

Test Plan:
- Default params, one CS-low frame of 80 SCLKs with words 0x2200, 0x1234, 0xABCD, 0x8000, 0x7FFF, frame_ready=1 -> one frame_valid pulse; frame_data = {0x7FFF,0x8000,0xABCD,0x1234,0x2200}; frame_error stays 0.
- WORD_BITS=24, DATA_BITS=24, NUM_CHANNELS=2, words 0x220000, 0x800001, 0x7FFFFE -> frame_data = {0x7FFFFE,0x800001,0x220000}.
- CS raised after 37 SCLKs (default params) -> frame_error pulses 1 cycle; frame_valid stays 0; the next full frame captures correctly.
- frame_ready=0, three back-to-back frames -> frame_data holds frame 1 and busy toggles per frame. With ADC_CAPTURE_DROP_CNT_EN, drop_count=2. Raising frame_ready then gives exactly one transfer.
- frame_valid high with frame_ready asserted in the DONE cycle of the next frame -> frame_valid stays 1, frame_data updates to the new frame, no drop counted.
- Reset asserted mid-frame with CS kept low, released, then 40 more SCLKs -> no output and no error. The next CS high->low frame captures normally. capture_en=0 at CS fall -> that frame ignored.
